// File: rtl/yarp_branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : yarp_branch_predictor_if
// Description : Lookup, update and result bundle for the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
interface yarp_branch_predictor_if;
   logic [31:0] lookup_pc_i;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_taken_i;
   logic [31:0] upd_target_i;
   logic        upd_pred_taken_i;
   logic [31:0] upd_pred_target_i;
   logic        flush_i;
   logic        mispredict_o;
   logic [31:0] redirect_pc_o;
   logic [15:0] mispred_cnt_o;

   modport master (
      output lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
             upd_pred_taken_i, upd_pred_target_i, flush_i,
      input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o, mispred_cnt_o
   );

   modport slave (
      input  lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
             upd_pred_taken_i, upd_pred_target_i, flush_i,
      output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o, mispred_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/yarp_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : yarp_branch_predictor
// Description : Direct-mapped BTB with 2-bit counters and mispredict detection.
// Revision    : 1.0 - initial release
// ============================================================================
module yarp_branch_predictor #(
   parameter int ENTRIES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   yarp_branch_predictor_if.slave  bp
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [31:0]        r_target [ENTRIES];
   logic [1:0]         r_ctr    [ENTRIES];

   logic        r_mispredict;
   logic [31:0] r_redirect_pc;
   logic [15:0] r_mispred_cnt;

   logic [IDX_W-1:0] w_lk_idx, w_upd_idx;
   logic [TAG_W-1:0] w_lk_tag, w_upd_tag;
   logic             w_lk_hit, w_upd_hit;
   logic [31:0]      w_correct_pc;
   logic             w_mispredict;
   logic             w_unused;

   assign w_lk_idx  = bp.lookup_pc_i[IDX_W+1:2];
   assign w_lk_tag  = bp.lookup_pc_i[31:IDX_W+2];
   assign w_upd_idx = bp.upd_pc_i[IDX_W+1:2];
   assign w_upd_tag = bp.upd_pc_i[31:IDX_W+2];
   assign w_unused  = &{bp.lookup_pc_i[1:0], bp.upd_pc_i[1:0]};

   assign w_lk_hit  = r_valid[w_lk_idx]  && (r_tag[w_lk_idx]  == w_lk_tag);
   assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

   // Lookup reads only registered state, so a same-cycle update is not bypassed.
   assign bp.pred_taken_o  = w_lk_hit && r_ctr[w_lk_idx][1];
   assign bp.pred_target_o = bp.pred_taken_o ? r_target[w_lk_idx] : bp.lookup_pc_i + 32'd4;

   assign w_correct_pc = bp.upd_taken_i ? bp.upd_target_i : bp.upd_pc_i + 32'd4;
   assign w_mispredict = (bp.upd_taken_i != bp.upd_pred_taken_i) ||
                         (bp.upd_taken_i && (bp.upd_pred_target_i != bp.upd_target_i));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_ctr[i] <= 2'b01;
         end
      end else if (bp.flush_i) begin
         r_valid <= '0;
      end else if (bp.upd_valid_i) begin
         if (w_upd_hit) begin
            if (bp.upd_taken_i) begin
               if (r_ctr[w_upd_idx] != 2'b11) r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'b01;
               r_target[w_upd_idx] <= bp.upd_target_i;
            end else if (r_ctr[w_upd_idx] != 2'b00) begin
               r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'b01;
            end
         end else if (bp.upd_taken_i) begin
            r_valid[w_upd_idx]  <= 1'b1;
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= bp.upd_target_i;
            r_ctr[w_upd_idx]    <= 2'b10;
         end
      end
   end

   // Result registers ignore flush: a flushed update still reports its outcome.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mispredict  <= 1'b0;
         r_redirect_pc <= 32'd0;
         r_mispred_cnt <= 16'd0;
      end else if (bp.upd_valid_i) begin
         r_mispredict  <= w_mispredict;
         r_redirect_pc <= w_correct_pc;
         if (w_mispredict && (r_mispred_cnt != 16'hFFFF)) begin
            r_mispred_cnt <= r_mispred_cnt + 16'd1;
         end
      end else begin
         r_mispredict <= 1'b0;
      end
   end

   assign bp.mispredict_o  = r_mispredict;
   assign bp.redirect_pc_o = r_redirect_pc;
   assign bp.mispred_cnt_o = r_mispred_cnt;
endmodule
`default_nettype wire

// File: tb/tb_yarp_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_yarp_branch_predictor
// Description : Directed cycle-table bench for yarp_branch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_yarp_branch_predictor;
   logic clk;
   logic reset;
   yarp_branch_predictor_if bp ();

   yarp_branch_predictor #(.ENTRIES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bp    (bp.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] lk_pc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic        upt;
      logic [31:0] uptgt;
      logic        fl;
      logic        e_pt;
      logic [31:0] e_ptgt;
      logic        e_mis;
      logic [31:0] e_red;
      logic [15:0] e_cnt;
   } vec_t;

   localparam int N_VEC = 21;
   vec_t vecs [N_VEC];
   int   n_applied = 0;
   int   n_miscompare = 0;

   function automatic vec_t mk(logic [31:0] lk_pc, logic uv, logic [31:0] upc, logic ut,
                               logic [31:0] utgt, logic upt, logic [31:0] uptgt, logic fl,
                               logic e_pt, logic [31:0] e_ptgt, logic e_mis,
                               logic [31:0] e_red, logic [15:0] e_cnt);
      vec_t v;
      v.lk_pc = lk_pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
      v.upt = upt; v.uptgt = uptgt; v.fl = fl; v.e_pt = e_pt; v.e_ptgt = e_ptgt;
      v.e_mis = e_mis; v.e_red = e_red; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miscompare++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic e_pt, input logic [31:0] e_ptgt,
                            input logic e_mis, input logic [31:0] e_red, input logic [15:0] e_cnt);
      check({tag, ".pred_taken"},  {31'd0, bp.pred_taken_o}, {31'd0, e_pt});
      check({tag, ".pred_target"}, bp.pred_target_o, e_ptgt);
      check({tag, ".mispredict"},  {31'd0, bp.mispredict_o}, {31'd0, e_mis});
      check({tag, ".redirect_pc"}, bp.redirect_pc_o, e_red);
      check({tag, ".mispred_cnt"}, {16'd0, bp.mispred_cnt_o}, {16'd0, e_cnt});
   endtask

   task automatic drive(input logic [31:0] lk_pc, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utgt, input logic upt,
                        input logic [31:0] uptgt, input logic fl);
      bp.lookup_pc_i       = lk_pc;
      bp.upd_valid_i       = uv;
      bp.upd_pc_i          = upc;
      bp.upd_taken_i       = ut;
      bp.upd_target_i      = utgt;
      bp.upd_pred_taken_i  = upt;
      bp.upd_pred_target_i = uptgt;
      bp.flush_i           = fl;
   endtask

   initial begin
      // Each row: inputs for this cycle; expected lookup outputs before the edge and
      // registered outputs produced by the previous row's update.
      //              lookup        uv upd_pc        t  target        pt ptarget       fl  ept etgt          emis ered          ecnt
      vecs[0]  = mk(32'h100,      0, 32'h0,        0, 32'h0,       0, 32'h0,       0,  0, 32'h104,      0, 32'h0,        16'd0);
      vecs[1]  = mk(32'h100,      1, 32'h100,      1, 32'h200,     0, 32'h104,     0,  0, 32'h104,      0, 32'h0,        16'd0);
      vecs[2]  = mk(32'h100,      0, 32'h0,        0, 32'h0,       0, 32'h0,       0,  1, 32'h200,      1, 32'h200,      16'd1);
      vecs[3]  = mk(32'h100,      1, 32'h100,      0, 32'h200,     1, 32'h200,     0,  1, 32'h200,      0, 32'h200,      16'd1);
      vecs[4]  = mk(32'h100,      1, 32'h100,      0, 32'h200,     0, 32'h104,     0,  0, 32'h104,      1, 32'h104,      16'd2);
      vecs[5]  = mk(32'h100,      1, 32'h100,      0, 32'h200,     0, 32'h104,     0,  0, 32'h104,      0, 32'h104,      16'd2);
      vecs[6]  = mk(32'h100,      0, 32'h0,        0, 32'h0,       0, 32'h0,       0,  0, 32'h104,      0, 32'h104,      16'd2);
      vecs[7]  = mk(32'h140,      1, 32'h140,      1, 32'h500,     0, 32'h144,     0,  0, 32'h144,      0, 32'h104,      16'd2);
      vecs[8]  = mk(32'h100,      0, 32'h0,        0, 32'h0,       0, 32'h0,       0,  0, 32'h104,      1, 32'h500,      16'd3);
      vecs[9]  = mk(32'h140,      0, 32'h0,        0, 32'h0,       0, 32'h0,       0,  1, 32'h500,      0, 32'h500,      16'd3);
      vecs[10] = mk(32'h140,      1, 32'h140,      1, 32'h600,     1, 32'h500,     0,  1, 32'h500,      0, 32'h500,      16'd3);
      vecs[11] = mk(32'h140,      0, 32'h0,        0, 32'h0,       0, 32'h0,       0,  1, 32'h600,      1, 32'h600,      16'd4);
      vecs[12] = mk(32'h140,      1, 32'h140,      1, 32'h600,     1, 32'h600,     0,  1, 32'h600,      0, 32'h600,      16'd4);
      vecs[13] = mk(32'h140,      0, 32'h0,        0, 32'h0,       0, 32'h0,       0,  1, 32'h600,      0, 32'h600,      16'd4);
      vecs[14] = mk(32'h140,      1, 32'h300,      1, 32'h700,     0, 32'h304,     1,  1, 32'h600,      0, 32'h600,      16'd4);
      vecs[15] = mk(32'h140,      0, 32'h0,        0, 32'h0,       0, 32'h0,       0,  0, 32'h144,      1, 32'h700,      16'd5);
      vecs[16] = mk(32'h300,      0, 32'h0,        0, 32'h0,       0, 32'h0,       0,  0, 32'h304,      0, 32'h700,      16'd5);
      vecs[17] = mk(32'h300,      1, 32'h300,      0, 32'h700,     0, 32'h304,     0,  0, 32'h304,      0, 32'h700,      16'd5);
      vecs[18] = mk(32'h300,      0, 32'h0,        0, 32'h0,       0, 32'h0,       0,  0, 32'h304,      0, 32'h304,      16'd5);
      vecs[19] = mk(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0,       1, 32'h40,      0,  0, 32'h0,        0, 32'h304,      16'd5);
      vecs[20] = mk(32'h300,      0, 32'h0,        0, 32'h0,       0, 32'h0,       0,  0, 32'h304,      1, 32'h0,        16'd6);

      reset = 1'b1;
      drive(32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < N_VEC; i++) begin
         @(negedge clk);
         drive(vecs[i].lk_pc, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt,
               vecs[i].upt, vecs[i].uptgt, vecs[i].fl);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_pt, vecs[i].e_ptgt,
                   vecs[i].e_mis, vecs[i].e_red, vecs[i].e_cnt);
      end

      // Counter saturation: back-to-back mispredicts from a fresh reset.
      @(negedge clk);
      reset = 1'b1;
      drive(32'h800, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      @(negedge clk);
      reset = 1'b0;
      drive(32'h800, 1, 32'h800, 1, 32'h900, 0, 32'h804, 0);
      repeat (65534) @(posedge clk);
      @(negedge clk); #1;
      check("sat.cnt_fffe", {16'd0, bp.mispred_cnt_o}, 32'h0000FFFE);
      check("sat.mis_fffe", {31'd0, bp.mispredict_o}, 32'd1);
      @(negedge clk); #1;
      check("sat.cnt_ffff", {16'd0, bp.mispred_cnt_o}, 32'h0000FFFF);
      @(negedge clk); #1;
      check("sat.cnt_hold", {16'd0, bp.mispred_cnt_o}, 32'h0000FFFF);
      check("sat.mis_hold", {31'd0, bp.mispredict_o}, 32'd1);
      check("sat.redirect", bp.redirect_pc_o, 32'h900);

      // Reset mid-sequence with an update pending: update is discarded.
      @(negedge clk);
      reset = 1'b1;
      drive(32'h800, 1, 32'h800, 1, 32'hA00, 0, 32'h804, 0);
      @(negedge clk); #1;
      check_all("rst", 1'b0, 32'h804, 1'b0, 32'h0, 16'd0);
      reset = 1'b0;
      drive(32'h800, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      @(negedge clk); #1;
      check_all("post_rst", 1'b0, 32'h804, 1'b0, 32'h0, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
      $finish;
   end
endmodule
`default_nettype wire
